gerador_janela_3x3: RTL
=======================

// Module: gerador_janela_3x3
// PURPOSE
// - Streams raster-order pixels in and produces a 3x3 neighbourhood window (n1_n..n9_n) every valid cycle.
// - Feeds the combinational median filter, which consumes ena + n1_n..n9_n. This block is the producer side of that interface.
// - Uses two internal line buffers of IMG_W entries each, plus a 3x3 shift-register window.
// PARAMETERS
// - DATA_W  8   pixel width in bits
// - IMG_W   16  pixels per line; must be >= 3
// - IMG_H   16  lines per frame; must be >= 3
// PORTS
// - clk          in   1       single clock, rising edge
// - rst_n        in   1       asynchronous reset, active low
// - ena          in   1       pixel input enable; when 0 the block holds all state
// - pix_valid    in   1       pix_in is valid this cycle
// - pix_in       in   DATA_W  input pixel, raster order
// - pix_ready    out  1       combinational; equals ena. A pixel is accepted when pix_valid & pix_ready
// - out_valid    out  1       window valid; registered one-cycle pulse per window; drives the filter's ena
// - n1_n..n9_n   out  DATA_W  window in raster order (each a separate port)
//                             n1 = top-left, n5 = centre, n9 = bottom-right; all registered
// - frame_done   out  1       one-cycle pulse, registered, after the last pixel of a frame is accepted
// BEHAVIOUR
// - Reset (async, rst_n=0):
//   - col=0, row=0; state=FILL; out_valid=0; frame_done=0; n1_n..n9_n=0.
//   - Line buffer contents are not cleared. They are never exposed, because output is gated by row/col.
// - Counters: col counts 0..IMG_W-1 and wraps to 0, incrementing row.
//   - row counts 0..IMG_H-1 and wraps to 0 at end of frame, with frame_done=1 on the next cycle.
// - Accept cycle, for pixel p at (row,col):
//   - Window columns shift left.
//   - New right column = {lb1[col], lb0[col], p}, i.e. (row-2, row-1, row).
//   - lb1[col] <= lb0[col]; lb0[col] <= p.
// - FSM: FILL (row<2) -> STREAM when row becomes 2; STREAM -> FILL at frame wrap.
// - out_valid=1 on the cycle after accepting a pixel with state=STREAM and col>=2.
//   - The window is then centred at (row-1,col-1). Latency is 1 clock.
//   - Windows per frame = (IMG_W-2)*(IMG_H-2). There is no border padding; border pixels produce no window.
//   - Window regs update on every accept. Their value is meaningful only while out_valid=1.
// - Non-accept cycle (ena=0 or pix_valid=0): counters, window and line buffers hold.
//   - out_valid=0 and frame_done=0 on the following cycle.
// - Unsigned arithmetic throughout.
//   - col width = $clog2(IMG_W); row width = $clog2(IMG_H).
//   - Wrap is by compare to IMG_W-1 / IMG_H-1, not by overflow.
// - Reset mid-frame: state is immediately at reset values. The next accepted pixel is treated as (0,0).
// CONFIGURATION
// - SOF_SYNC_EN defined:
//   - Adds input port sof (1 bit), sampled only on accept.
//   - sof=1 forces that pixel to (0,0): row=0, col=1 after accept, state=FILL.
//   - No out_valid for that pixel; frame_done is not pulsed.
// - SOF_SYNC_EN undefined: no sof port; framing is purely by counters from reset.
// TESTING (IMG_W=4, IMG_H=4)
// - T1 raster ramp: pixels 0..15 streamed, one per cycle, ena=1.
//   - First out_valid follows pixel 10, window = 0,1,2,4,5,6,8,9,10.
//   - Next follows pixel 11, window = 1,2,3,5,6,7,9,10,11.
//   - No out_valid after pixels 12 or 13.
//   - After pixel 14: 4,5,6,8,9,10,12,13,14.
//   - Exactly 4 windows; frame_done 1 cycle after pixel 15.
// - T2 constant frame: all pixels 7 -> every window is 7 x9; the median filter output is 7.
// - T3 stall: ena=0 for 3 cycles between pixels 10 and 11.
//   - pix_ready=0 and out_valid=0 during the stall.
//   - Window after pixel 11 is identical to T1.
// - T4 back-to-back frames: stream 32 pixels.
//   - The second frame yields the same 4 windows with its values.
//   - Two frame_done pulses; no window spans the frame boundary.
// - T5 reset mid-frame: rst_n=0 after pixel 9, then replay 0..15.
//   - Outputs are 0 during reset; results then match T1 exactly.
// - T6 (SOF_SYNC_EN): send 5 junk pixels, then sof=1 with pixel 0, then 1..15.
//   - Windows match T1; no frame_done for the aborted frame.

Source files
------------

// File: rtl/gerador_janela_3x3.sv
// gerador_janela_3x3: raster-order 3x3 window generator built from two line buffers and a 3x3 shift window.
// Define SOF_SYNC_EN to add the sof input, which restarts framing at the pixel it accompanies.
module gerador_janela_3x3 #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 16,
  parameter int IMG_H  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              pix_valid,
  input  logic [DATA_W-1:0] pix_in,
`ifdef SOF_SYNC_EN
  input  logic              sof,
`endif
  output logic              pix_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] n1_n,
  output logic [DATA_W-1:0] n2_n,
  output logic [DATA_W-1:0] n3_n,
  output logic [DATA_W-1:0] n4_n,
  output logic [DATA_W-1:0] n5_n,
  output logic [DATA_W-1:0] n6_n,
  output logic [DATA_W-1:0] n7_n,
  output logic [DATA_W-1:0] n8_n,
  output logic [DATA_W-1:0] n9_n,
  output logic              frame_done
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [0:0] FILL   = 1'b0;
  localparam logic [0:0] STREAM = 1'b1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  logic [CW-1:0] col, ccol, ncol;
  logic [RW-1:0] row, crow, nrow;
  logic [0:0] state;
  logic acc, sof_hit, col_last, row_last;
  logic [DATA_W-1:0] lb0 [IMG_W];
  logic [DATA_W-1:0] lb1 [IMG_W];
  logic [DATA_W-1:0] w [3][3];
  assign pix_ready = ena;
  assign acc = ena & pix_valid;
`ifdef SOF_SYNC_EN
  assign sof_hit = acc & sof;
`else
  assign sof_hit = 1'b0;
`endif
  // a sof pixel is placed at (0,0) regardless of where the counters stood
  assign ccol = sof_hit ? '0 : col;
  assign crow = sof_hit ? '0 : row;
  assign col_last = ccol == COL_LAST;
  assign row_last = crow == ROW_LAST;
  assign ncol = col_last ? '0 : ccol + CW'(1);
  assign nrow = col_last ? (row_last ? '0 : crow + RW'(1)) : crow;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
      state <= FILL;
      out_valid <= 1'b0;
      frame_done <= 1'b0;
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++) w[i][j] <= '0;
    end else begin
      out_valid <= acc & ~sof_hit & (state == STREAM) & (col >= CW'(2));
      frame_done <= acc & col_last & row_last;
      if (acc) begin
        col <= ncol;
        row <= nrow;
        state <= (nrow >= RW'(2)) ? STREAM : FILL;
        for (int i = 0; i < 3; i++) begin
          w[i][0] <= w[i][1];
          w[i][1] <= w[i][2];
        end
        w[0][2] <= lb1[ccol];
        w[1][2] <= lb0[ccol];
        w[2][2] <= pix_in;
      end
    end
  end
  // line buffers are never exposed before being rewritten, so they carry no reset
  always_ff @(posedge clk) begin
    if (acc) begin
      lb1[ccol] <= lb0[ccol];
      lb0[ccol] <= pix_in;
    end
  end
  assign n1_n = w[0][0];
  assign n2_n = w[0][1];
  assign n3_n = w[0][2];
  assign n4_n = w[1][0];
  assign n5_n = w[1][1];
  assign n6_n = w[1][2];
  assign n7_n = w[2][0];
  assign n8_n = w[2][1];
  assign n9_n = w[2][2];
endmodule
